// File: rtl/pipe_pkg.sv
// Shared types and widths for the memory-to-writeback pipeline boundary.
package pipe_pkg;
    localparam int DATA_W     = 24;
    localparam int REG_ADDR_W = 4;
    localparam int CNT_W      = 32;

    typedef struct packed {
        logic                  valid;
        logic                  we;
        logic                  load;
        logic [REG_ADDR_W-1:0] rd;
    } wb_ctrl_t;

    typedef enum logic {RUN = 1'b0, HELD = 1'b1} wb_state_t;
endpackage

// File: rtl/mem_to_wb_stage_if.sv
// Memory-stage inputs, register-file write port and forwarding bus of the WB stage.
interface mem_to_wb_stage_if #(
    parameter int DATA_W     = pipe_pkg::DATA_W,
    parameter int REG_ADDR_W = pipe_pkg::REG_ADDR_W,
    parameter int CNT_W      = pipe_pkg::CNT_W
);
    logic                  valid_in;
    logic                  writeback_enable;
    logic                  read_enable;
    logic [DATA_W-1:0]     result;
    logic [DATA_W-1:0]     mem_read_data;
    logic [REG_ADDR_W-1:0] rd_in;
    logic                  stall;
    logic                  flush;
    logic                  reg_write_enable;
    logic [REG_ADDR_W-1:0] reg_write_addr;
    logic [DATA_W-1:0]     reg_write_data;
    logic                  fwd_valid;
    logic [REG_ADDR_W-1:0] fwd_addr;
    logic [DATA_W-1:0]     fwd_data;
    logic [CNT_W-1:0]      retire_count;

    modport master (
        output valid_in, writeback_enable, read_enable, result, mem_read_data,
               rd_in, stall, flush,
        input  reg_write_enable, reg_write_addr, reg_write_data,
               fwd_valid, fwd_addr, fwd_data, retire_count
    );

    modport slave (
        input  valid_in, writeback_enable, read_enable, result, mem_read_data,
               rd_in, stall, flush,
        output reg_write_enable, reg_write_addr, reg_write_data,
               fwd_valid, fwd_addr, fwd_data, retire_count
    );
endinterface

// File: rtl/wb_stall_capture.sv
// Keeps a load's BRAM read data alive across a stall: the BRAM only presents
// it for one cycle, so it is captured on the edge the stall begins.
module wb_stall_capture
    import pipe_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              stall,
    input  logic              flush,
    input  logic              wb_valid,
    input  logic              wb_load,
    input  logic [DATA_W-1:0] mem_read_data,
    output logic [DATA_W-1:0] load_data
);
    wb_state_t         state;
    logic [DATA_W-1:0] hold_data;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= RUN;
            hold_data <= '0;
        end else begin
            case (state)
                RUN: begin
                    if (stall && !flush && wb_valid && wb_load) begin
                        state     <= HELD;
                        hold_data <= mem_read_data;
                    end
                end
                HELD: begin
                    // flush drops the held load; hold_data is left as-is
                    if (!stall || flush) state <= RUN;
                end
                default: state <= RUN;
            endcase
        end
    end

    assign load_data = (state == HELD) ? hold_data : mem_read_data;
endmodule

// File: rtl/mem_to_wb_stage.sv
// MEM/WB pipeline register and writeback select driving the register file and
// forwarding bus. Define MEM_WB_RETIRE_CNT_EN to build the retired-instruction counter.
module mem_to_wb_stage
    import pipe_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    mem_to_wb_stage_if.slave bus
);
    wb_ctrl_t          ctrl;
    logic [DATA_W-1:0] wb_result;
    logic [DATA_W-1:0] load_data;
    logic              write_en;
    logic [DATA_W-1:0] write_data;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ctrl      <= '0;
            wb_result <= '0;
        end else if (bus.flush) begin
            ctrl.valid <= 1'b0;
            ctrl.we    <= 1'b0;
        end else if (!bus.stall) begin
            ctrl      <= '{valid: bus.valid_in,
                           we:    bus.writeback_enable & bus.valid_in,
                           load:  bus.read_enable,
                           rd:    bus.rd_in};
            wb_result <= bus.result;
        end
    end

    wb_stall_capture u_capture (
        .clk           (clk),
        .rst           (rst),
        .stall         (bus.stall),
        .flush         (bus.flush),
        .wb_valid      (ctrl.valid),
        .wb_load       (ctrl.load),
        .mem_read_data (bus.mem_read_data),
        .load_data     (load_data)
    );

    // Write is held off while stalled so a held instruction commits exactly once.
    assign write_en   = ctrl.valid & ctrl.we & ~bus.stall & (ctrl.rd != '0);
    assign write_data = ctrl.load ? load_data : wb_result;

    assign bus.reg_write_enable = write_en;
    assign bus.reg_write_addr   = ctrl.rd;
    assign bus.reg_write_data   = write_data;
    assign bus.fwd_valid        = write_en;
    assign bus.fwd_addr         = ctrl.rd;
    assign bus.fwd_data         = write_data;

`ifdef MEM_WB_RETIRE_CNT_EN
    logic [CNT_W-1:0] retire_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)                          retire_q <= '0;
        else if (ctrl.valid && !bus.stall) retire_q <= retire_q + CNT_W'(1);
    end

    assign bus.retire_count = retire_q;
`else
    assign bus.retire_count = '0;
`endif
endmodule

// File: doc/mem_to_wb_stage.md
Name: mem_to_wb_stage

Overview:
- Pipeline register and writeback stage directly downstream of the memory stage.
- Latches the memory stage's writeback control, destination register and ALU/address result.
- Selects between the ALU result and synchronous-read memory data, and drives the register-file write port and a forwarding bus.
- Owns the stall-capture buffering needed because BRAM read data is only valid for one cycle after the request.

Parameters:
DATA_W, 24, datapath width (result, read data, write data)
REG_ADDR_W, 4, register-file index width
CNT_W, 32, retire-counter width (used only with the optional feature)

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous reset, active-low
valid_in  in  1  memory stage holds a real instruction this cycle
writeback_enable  in  1  instruction writes the register file
read_enable  in  1  instruction is a load
result  in  DATA_W  ALU result from the memory stage
mem_read_data  in  DATA_W  BRAM port-A read data; valid the cycle after the request
rd_in  in  REG_ADDR_W  destination register index
stall  in  1  hold the WB register contents
flush  in  1  insert a bubble into WB
reg_write_enable  out  1  register-file write strobe
reg_write_addr  out  REG_ADDR_W  register-file write index
reg_write_data  out  DATA_W  register-file write data
fwd_valid  out  1  forwarding bus valid (equals reg_write_enable)
fwd_addr  out  REG_ADDR_W  forwarding destination
fwd_data  out  DATA_W  forwarding data (equals reg_write_data)
retire_count  out  CNT_W  retired instructions (optional feature only)

Behaviour:
- Reset (rst=0, asynchronous): wb_valid, wb_we, wb_load, wb_rd, wb_result and hold_data all clear to 0; FSM goes to RUN. All outputs read 0.
- Register update each rising edge, in priority order:
  - flush=1: wb_valid and wb_we clear to 0. Flush beats stall.
  - else stall=1: all WB registers hold.
  - else: load {valid_in, writeback_enable & valid_in, read_enable, rd_in, result}.
- Latency: one cycle from memory-stage inputs to the register-file write. Load data arrives on mem_read_data during the same cycle the load occupies WB.
- Data select:
  - wb_load=0: write data is wb_result.
  - wb_load=1 in RUN: write data is mem_read_data.
  - wb_load=1 in HELD: write data is hold_data.
- Write strobe: reg_write_enable = wb_valid & wb_we & ~stall. The write is suppressed while stalled, so a held instruction writes exactly once, on the cycle stall falls.
- Write to register 0 is suppressed: reg_write_enable=0 when wb_rd==0. Forwarding outputs mirror the write port.
- FSM (stall capture):
  - RUN -> HELD: stall=1 & flush=0 & wb_valid & wb_load. Capture mem_read_data into hold_data on that edge.
  - HELD -> HELD: while stall=1. hold_data is frozen.
  - HELD -> RUN: stall=0 or flush=1.
  - RUN -> RUN: otherwise.
- Simultaneous stall and flush: flush wins. Bubble inserted, FSM to RUN, hold_data unchanged.
- Back-to-back loads without stall: no capture; each uses the live mem_read_data.
- Reset during HELD: FSM returns to RUN and nothing is written.

Optional Feature:
- Macro MEM_WB_RETIRE_CNT_EN.
- Defined: retire_count increments by 1 on every cycle with wb_valid & ~stall. This counts non-writing instructions too, including stores and writes to reg 0. It wraps modulo 2^CNT_W and resets to 0.
- Not defined: retire_count is tied to 0 and no counter logic is synthesised.

Decomposition:
- Shared package pipe_pkg:
  - DATA_W and REG_ADDR_W constants.
  - wb_ctrl_t struct {valid, we, load, rd}.
  - wb_state_t enum {RUN, HELD}.
- One natural sub-module: wb_stall_capture. It contains the FSM and hold_data register and outputs the selected load data.

Test Plan:
- ALU writeback: valid_in=1, writeback_enable=1, rd_in=3, result=24'h00ABCD -> next cycle reg_write_enable=1, reg_write_addr=3, reg_write_data=24'h00ABCD.
- Load without stall: read_enable=1, rd_in=5; mem_read_data=24'h123456 in the WB cycle -> reg_write_data=24'h123456, written once.
- Load with 3-cycle stall: mem_read_data=24'h111111 on the capture edge, then changes to 24'hFFFFFF:
  - reg_write_enable=0 during stall, FSM=HELD.
  - After stall drops, exactly one write of 24'h111111.
- Flush with stall: flush=1 and stall=1 on a pending ALU op to rd=7 -> no write, FSM=RUN, next instruction proceeds normally.
- Reg-0 and reset: write to rd=0 -> reg_write_enable stays 0. Assert rst=0 mid-HELD -> all outputs 0 immediately (asynchronously).
- With MEM_WB_RETIRE_CNT_EN: 10 valid instructions with 2 stall cycles interleaved -> retire_count=10. Without the macro -> retire_count=0.
